i2c_cfg_arbiter: RTL and testbench
==================================

I2C_CFG_ARBITER -- requirements
Module: i2c_cfg_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 20000: cycles allowed from i2c_exec to i2c_done before abort.
REQ-002 Parameter GAP_CYC, default 4: idle cycles inserted after every transaction; legal range 1..255.
REQ-003 clk  in  1  single clock, same clock as the shared i2c driver; all logic rising-edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req0 / req1  in  1  camera 0/1 configuration request, held high until ack.
REQ-006 rw0 / rw1  in  1  1 = register read, 0 = register write.
REQ-007 addr0 / addr1  in  16  OV5640 register address.
REQ-008 wdata0 / wdata1  in  8  write data.
REQ-009 ack0 / ack1  out  1  one-cycle completion pulse to requester.
REQ-010 rdata0 / rdata1  out  8  read data, valid with ack.
REQ-011 err0 / err1  out  1  valid with ack: 1 = NACK or timeout.
REQ-012 i2c_exec  out  1  one-cycle start pulse to shared i2c driver.
REQ-013 i2c_rh_wl  out  1  1 = read, 0 = write, to driver.
REQ-014 i2c_addr  out  16 / i2c_data_w  out  8  operands to driver.
REQ-015 i2c_done  in  1  driver completion pulse; i2c_ack  in  1  1 = slave NACK; i2c_data_r  in  8  read data.
REQ-016 bus_sel  out  1  selects camera bus (0 = cam0 scl/sda, 1 = cam1) at the pad mux.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, GAP; one-hot or binary at implementer's choice.
REQ-019 IDLE: if any req high, grant and move to ISSUE on next edge; with no req, stay.
REQ-020 Arbitration round-robin: one req -> that requester; both -> requester other than last_grant.
REQ-021 last_grant resets to 1, so cam0 wins the first simultaneous contest.
REQ-022 On grant edge: bus_sel, i2c_rh_wl, i2c_addr, i2c_data_w loaded from granted requester; held stable until next grant.
REQ-023 ISSUE lasts exactly one cycle with i2c_exec = 1; i2c_exec is 0 in all other states.
REQ-024 Latency: req sampled high at edge N -> i2c_exec high in cycle N+1 (bus_sel already switched).
REQ-025 WAIT: timeout counter increments each cycle from 0.
REQ-026 i2c_done high in WAIT -> next edge: ackG=1 for one cycle, errG=i2c_ack, rdataG=i2c_data_r if read (else unchanged), state GAP.
REQ-027 Counter reaches TIMEOUT_CYC-1 without i2c_done -> ackG=1, errG=1, rdataG unchanged, state GAP.
REQ-028 i2c_done and timeout in same cycle: done wins (err = i2c_ack).
REQ-029 i2c_done outside WAIT is ignored.
REQ-030 req deasserted during ISSUE/WAIT: transaction completes, ack still issued.
REQ-031 Non-granted requester's ack/err/rdata never change during another's transaction.
REQ-032 GAP: count GAP_CYC cycles, then IDLE; requester must drop req the cycle after ack, so stale req is never re-granted.

Reset
REQ-033 rst_n low (any time, including mid-WAIT): state IDLE, counters 0, all ack/err/i2c_exec/busy 0, rdata0/1 0x00, i2c_addr 0x0000, i2c_data_w 0x00, i2c_rh_wl 0, bus_sel 0, last_grant 1.
REQ-034 After rst_n rises, no i2c_exec before first sampled req.

Verification
REQ-035 Single write: req0, rw0=0, addr0=0x3008, wdata0=0x82 -> i2c_exec one cycle after, bus_sel=0, i2c_addr=0x3008, i2c_data_w=0x82; i2c_done with i2c_ack=0 -> ack0 pulse, err0=0.
REQ-036 Simultaneous: req0 and req1 high after reset -> cam0 served first, then cam1 (bus_sel=1) after GAP_CYC idle cycles; next contest goes to cam0.
REQ-037 Read: req1, rw1=1, addr1=0x300A; driver returns i2c_data_r=0x56 -> ack1 with rdata1=0x56, err1=0; rdata0 unchanged.
REQ-038 Timeout: no i2c_done with TIMEOUT_CYC=16 -> ack pulse with err=1 exactly 16 cycles after i2c_exec; done and timeout coincident -> err=i2c_ack.
REQ-039 NACK: i2c_done with i2c_ack=1 -> err=1; reset asserted mid-WAIT -> all outputs to REQ-033 values, late i2c_done after reset ignored.

Source files
------------

// File: rtl/i2c_cfg_arbiter.sv
// i2c_cfg_arbiter
// Shares one I2C register-access driver between two camera configuration
// requesters. Round-robin grant, one transaction at a time, with a timeout
// on the driver and a fixed idle gap after every transaction.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   reqN/rwN/addrN/wdataN      requester N command (held until ackN)
//   ackN/rdataN/errN           requester N completion (one-cycle ack)
//   i2c_exec/i2c_rh_wl/        start pulse and operands to the driver
//   i2c_addr/i2c_data_w
//   i2c_done/i2c_ack/          driver completion, NACK flag, read data
//   i2c_data_r
//   bus_sel                    pad mux select, 0 = cam0, 1 = cam1
//   busy                       high whenever not IDLE
module i2c_cfg_arbiter #(
  parameter int TIMEOUT_CYC = 20000,
  parameter int GAP_CYC     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        rw0,
  input  logic [15:0] addr0,
  input  logic [7:0]  wdata0,
  input  logic        req1,
  input  logic        rw1,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic [7:0]  rdata0,
  output logic        err0,
  output logic        ack1,
  output logic [7:0]  rdata1,
  output logic        err1,
  output logic        i2c_exec,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  input  logic [7:0]  i2c_data_r,
  output logic        bus_sel,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      GAP_LAST = 8'(GAP_CYC - 1);

  state_t        state;
  logic [TW-1:0] to_cnt;
  logic [7:0]    gap_cnt;
  logic          last_grant;
  logic          gnt_nxt;
  logic          fin;
  logic          fin_err;

  // Contest goes to whoever was not served last; a lone request wins outright.
  always_comb begin
    gnt_nxt = req1;
    if (req0 && req1) gnt_nxt = ~last_grant;
  end

  // Done beats a coincident timeout, so the driver's NACK flag is reported.
  assign fin     = i2c_done || (to_cnt >= TO_LAST);
  assign fin_err = i2c_done ? i2c_ack : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      to_cnt     <= '0;
      gap_cnt    <= '0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= 8'h00;
      rdata1     <= 8'h00;
      i2c_exec   <= 1'b0;
      i2c_rh_wl  <= 1'b0;
      i2c_addr   <= 16'h0000;
      i2c_data_w <= 8'h00;
      bus_sel    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      i2c_exec <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state      <= ISSUE;
            last_grant <= gnt_nxt;
            bus_sel    <= gnt_nxt;
            i2c_rh_wl  <= gnt_nxt ? rw1    : rw0;
            i2c_addr   <= gnt_nxt ? addr1  : addr0;
            i2c_data_w <= gnt_nxt ? wdata1 : wdata0;
            i2c_exec   <= 1'b1;
            busy       <= 1'b1;
            to_cnt     <= '0;
          end
        end
        // The timeout window starts on the exec cycle itself, so the
        // counter already runs during ISSUE.
        ISSUE: begin
          state  <= WAIT;
          to_cnt <= to_cnt + 1'b1;
        end
        WAIT: begin
          if (fin) begin
            state   <= GAP;
            gap_cnt <= '0;
            if (bus_sel) begin
              ack1 <= 1'b1;
              err1 <= fin_err;
              if (i2c_done && i2c_rh_wl) rdata1 <= i2c_data_r;
            end else begin
              ack0 <= 1'b1;
              err0 <= fin_err;
              if (i2c_done && i2c_rh_wl) rdata0 <= i2c_data_r;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        // Requesters drop req the cycle after ack; the gap keeps that stale
        // req from being sampled.
        GAP: begin
          if (gap_cnt >= GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
// Directed bench for i2c_cfg_arbiter (TIMEOUT_CYC=16, GAP_CYC=4).
// Inputs are driven and outputs sampled on the falling edge.
module tb_i2c_cfg_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, rw0, req1, rw1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [7:0]  rdata0, rdata1;
  logic        i2c_exec, i2c_rh_wl, i2c_done, i2c_ack;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w, i2c_data_r;
  logic        bus_sel, busy;

  int n_chk  = 0;
  int n_fail = 0;

  i2c_cfg_arbiter #(.TIMEOUT_CYC(16), .GAP_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl), .i2c_addr(i2c_addr),
    .i2c_data_w(i2c_data_w), .i2c_done(i2c_done), .i2c_ack(i2c_ack),
    .i2c_data_r(i2c_data_r), .bus_sel(bus_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Runs one transaction for requester 'who'. Done is driven 'dly' cycles
  // after the exec cycle (dly >= 1 lands in WAIT). Reports what was seen.
  task automatic do_txn(input bit who, input bit rw, input logic [15:0] a,
                        input logic [7:0] wd, input logic [7:0] rd,
                        input bit nack, input int dly,
                        output bit got_exec, output bit got_ack,
                        output logic got_err, output logic [7:0] got_rd,
                        output bit oth_ack, output bit idle_ok);
    oth_ack = 1'b0;
    idle_ok = 1'b0;
    @(negedge clk);
    if (who) begin req1 = 1; rw1 = rw; addr1 = a; wdata1 = wd; end
    else     begin req0 = 1; rw0 = rw; addr0 = a; wdata0 = wd; end
    @(negedge clk);
    got_exec = i2c_exec;
    repeat (dly) begin
      @(negedge clk);
      if (who ? ack0 : ack1) oth_ack = 1'b1;
    end
    i2c_done = 1; i2c_ack = nack; i2c_data_r = rd;
    @(negedge clk);
    i2c_done = 0; i2c_ack = 0;
    got_ack = who ? ack1 : ack0;
    got_err = who ? err1 : err0;
    got_rd  = who ? rdata1 : rdata0;
    if (who ? ack0 : ack1) oth_ack = 1'b1;
    req0 = 0; req1 = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (who ? ack0 : ack1) oth_ack = 1'b1;
      if (!busy) begin idle_ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 0; req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    i2c_done = 0; i2c_ack = 0; i2c_data_r = 0;
    repeat (2) @(negedge clk);
    n_chk++; if (i2c_exec !== 1'b0) begin n_fail++; $display("FAIL reset_exec: got %b want 0", i2c_exec); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if ({ack0, ack1, err0, err1} !== 4'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b want 0000", {ack0, ack1, err0, err1}); end
    n_chk++; if ({rdata0, rdata1} !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", {rdata0, rdata1}); end
    n_chk++; if (i2c_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", i2c_addr); end
    n_chk++; if ({i2c_data_w, i2c_rh_wl, bus_sel} !== 10'h0) begin n_fail++; $display("FAIL reset_ops: got %h want 000", {i2c_data_w, i2c_rh_wl, bus_sel}); end
    rst_n = 1;
    begin
      bit seen = 0;
      repeat (5) begin @(negedge clk); if (i2c_exec || busy) seen = 1; end
      n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_no_exec: got activity %b want 0", seen); end
    end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    req0 = 1; rw0 = 0; addr0 = 16'h3008; wdata0 = 8'h82;
    @(negedge clk);
    n_chk++; if (i2c_exec !== 1'b1) begin n_fail++; $display("FAIL wr_exec_latency: got %b want 1", i2c_exec); end
    n_chk++; if (bus_sel !== 1'b0) begin n_fail++; $display("FAIL wr_bus_sel: got %b want 0", bus_sel); end
    n_chk++; if (i2c_addr !== 16'h3008) begin n_fail++; $display("FAIL wr_addr: got %h want 3008", i2c_addr); end
    n_chk++; if (i2c_data_w !== 8'h82) begin n_fail++; $display("FAIL wr_data: got %h want 82", i2c_data_w); end
    n_chk++; if (i2c_rh_wl !== 1'b0) begin n_fail++; $display("FAIL wr_rh_wl: got %b want 0", i2c_rh_wl); end
    @(negedge clk);
    n_chk++; if (i2c_exec !== 1'b0) begin n_fail++; $display("FAIL wr_exec_one_cycle: got %b want 0", i2c_exec); end
    i2c_done = 1; i2c_ack = 0;
    @(negedge clk);
    i2c_done = 0;
    n_chk++; if ({ack0, err0, ack1} !== 3'b100) begin n_fail++; $display("FAIL wr_ack0: got ack0/err0/ack1 %b want 100", {ack0, err0, ack1}); end
    req0 = 0;
    @(negedge clk);
    n_chk++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL wr_ack_pulse: got %b want 0", ack0); end
    repeat (2) @(negedge clk);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_gap_busy: got %b want 1", busy); end
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_gap_end: got %b want 0", busy); end
  endtask

  task automatic test_simultaneous();
    int k;
    bit a1_early = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    req0 = 1; rw0 = 0; addr0 = 16'h1111; wdata0 = 8'h11;
    req1 = 1; rw1 = 0; addr1 = 16'h2222; wdata1 = 8'h22;
    @(negedge clk);
    n_chk++; if ({i2c_exec, bus_sel, i2c_addr} !== {2'b10, 16'h1111}) begin n_fail++; $display("FAIL sim_first_cam0: got exec/sel/addr %b%b %h want 10 1111", i2c_exec, bus_sel, i2c_addr); end
    @(negedge clk);
    i2c_done = 1;
    @(negedge clk);
    i2c_done = 0;
    n_chk++; if ({ack0, ack1} !== 2'b10) begin n_fail++; $display("FAIL sim_ack0: got %b want 10", {ack0, ack1}); end
    req0 = 0;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack1) a1_early = 1;
      if (i2c_exec) break;
    end
    n_chk++; if (k !== 5) begin n_fail++; $display("FAIL sim_gap_len: got exec after %0d cycles want 5", k); end
    n_chk++; if ({bus_sel, i2c_addr, i2c_data_w} !== {1'b1, 16'h2222, 8'h22}) begin n_fail++; $display("FAIL sim_second_cam1: got %b %h %h want 1 2222 22", bus_sel, i2c_addr, i2c_data_w); end
    n_chk++; if (a1_early !== 1'b0) begin n_fail++; $display("FAIL sim_ack1_early: got %b want 0", a1_early); end
    @(negedge clk);
    i2c_done = 1;
    @(negedge clk);
    i2c_done = 0;
    n_chk++; if ({ack0, ack1} !== 2'b01) begin n_fail++; $display("FAIL sim_ack1: got %b want 01", {ack0, ack1}); end
    req1 = 0;
    for (k = 0; k < 30 && busy; k++) @(negedge clk);
    req0 = 1; req1 = 1;
    @(negedge clk);
    n_chk++; if ({i2c_exec, bus_sel} !== 2'b10) begin n_fail++; $display("FAIL sim_next_contest: got exec/sel %b want 10", {i2c_exec, bus_sel}); end
    // Requests withdrawn mid-transaction: ack must still arrive.
    req0 = 0; req1 = 0;
    @(negedge clk);
    i2c_done = 1;
    @(negedge clk);
    i2c_done = 0;
    n_chk++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL sim_withdrawn_ack: got %b want 1", ack0); end
    for (k = 0; k < 30 && busy; k++) @(negedge clk);
  endtask

  task automatic test_read();
    bit ex, ak, oa, idl;
    logic er;
    logic [7:0] rd;
    do_txn(0, 1, 16'h300B, 8'h00, 8'hA5, 0, 2, ex, ak, er, rd, oa, idl);
    n_chk++; if ({ex, ak, er, rd} !== {3'b110, 8'hA5}) begin n_fail++; $display("FAIL rd0: got exec/ack/err/rdata %b%b%b %h want 110 a5", ex, ak, er, rd); end
    do_txn(1, 1, 16'h300A, 8'h00, 8'h56, 0, 3, ex, ak, er, rd, oa, idl);
    n_chk++; if ({ex, ak, er, rd} !== {3'b110, 8'h56}) begin n_fail++; $display("FAIL rd1: got exec/ack/err/rdata %b%b%b %h want 110 56", ex, ak, er, rd); end
    n_chk++; if ({oa, rdata0, err0} !== {1'b0, 8'hA5, 1'b0}) begin n_fail++; $display("FAIL rd1_other_stable: got ack0seen/rdata0/err0 %b %h %b want 0 a5 0", oa, rdata0, err0); end
    n_chk++; if (idl !== 1'b1) begin n_fail++; $display("FAIL rd1_idle: got %b want 1", idl); end
  endtask

  task automatic test_timeout();
    int k;
    @(negedge clk);
    req0 = 1; rw0 = 1; addr0 = 16'h300C;
    @(negedge clk);
    // Done during ISSUE is outside WAIT and must be ignored.
    i2c_done = 1; i2c_data_r = 8'hEE;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      i2c_done = 0;
      if (ack0) break;
    end
    n_chk++; if (k !== 16) begin n_fail++; $display("FAIL to_latency: got ack %0d cycles after exec want 16", k); end
    n_chk++; if ({err0, rdata0} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL to_err_rdata: got %b %h want 1 a5", err0, rdata0); end
    req0 = 0;
    for (k = 0; k < 30 && busy; k++) @(negedge clk);
  endtask

  task automatic test_coincident_and_nack();
    bit ex, ak, oa, idl;
    logic er;
    logic [7:0] rd;
    do_txn(1, 0, 16'h3103, 8'h03, 8'h00, 0, 15, ex, ak, er, rd, oa, idl);
    n_chk++; if ({ak, er} !== 2'b10) begin n_fail++; $display("FAIL coincident_done_wins: got ack/err %b want 10", {ak, er}); end
    do_txn(0, 0, 16'h3008, 8'h02, 8'h00, 1, 4, ex, ak, er, rd, oa, idl);
    n_chk++; if ({ak, er} !== 2'b11) begin n_fail++; $display("FAIL nack_err: got ack/err %b want 11", {ak, er}); end
  endtask

  task automatic test_done_outside_wait();
    bit seen = 0;
    @(negedge clk);
    i2c_done = 1; i2c_ack = 1;
    @(negedge clk);
    i2c_done = 0; i2c_ack = 0;
    repeat (3) begin
      if (ack0 || ack1 || i2c_exec || busy) seen = 1;
      @(negedge clk);
    end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL idle_done_ignored: got activity %b want 0", seen); end
  endtask

  task automatic test_reset_mid_wait();
    bit seen = 0;
    @(negedge clk);
    req1 = 1; rw1 = 1; addr1 = 16'h4321; wdata1 = 8'h77;
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    n_chk++; if ({busy, i2c_exec, bus_sel, i2c_rh_wl} !== 4'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got %b want 0000", {busy, i2c_exec, bus_sel, i2c_rh_wl}); end
    n_chk++; if ({i2c_addr, i2c_data_w, rdata0, rdata1} !== 40'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h want 0", {i2c_addr, i2c_data_w, rdata0, rdata1}); end
    n_chk++; if ({ack0, ack1, err0, err1} !== 4'b0) begin n_fail++; $display("FAIL rst_mid_ack: got %b want 0000", {ack0, ack1, err0, err1}); end
    req1 = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    i2c_done = 1; i2c_data_r = 8'h99;
    @(negedge clk);
    i2c_done = 0;
    repeat (3) begin
      if (ack0 || ack1 || i2c_exec || busy || rdata1 != 8'h00) seen = 1;
      @(negedge clk);
    end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_late_done: got activity %b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_simultaneous();
    test_read();
    test_timeout();
    test_coincident_and_nack();
    test_done_outside_wait();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
